// File: rtl/fifo36_to_fifo19_pkg.sv
// Shared constants and line layouts for the 36-bit to 19-bit packet FIFO converter.
package fifo36_to_fifo19_pkg;

  localparam int unsigned F36_W  = 36;
  localparam int unsigned F19_W  = 19;
  localparam int unsigned HALF_W = 16;

  // Decoupling FIFO geometry
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned FIFO_AW    = 4;
  localparam int unsigned FIFO_CW    = 5;

  // f36 occ codes; only meaningful on an eof line
  localparam logic [1:0] OCC_4B = 2'd0;
  localparam logic [1:0] OCC_1B = 2'd1;
  localparam logic [1:0] OCC_2B = 2'd2;
  localparam logic [1:0] OCC_3B = 2'd3;

  // Half-select phase
  localparam logic [0:0] PH0 = 1'b0;
  localparam logic [0:0] PH1 = 1'b1;

  typedef struct packed {
    logic [1:0]  occ;
    logic        eof;
    logic        sof;
    logic [31:0] data;
  } f36_line_t;

  typedef struct packed {
    logic              occ;
    logic              eof;
    logic              sof;
    logic [HALF_W-1:0] data;
  } f19_line_t;

endpackage

// File: rtl/fifo36_to_fifo19_fifo_short.sv
// fifo_short: 16-entry valid/ready FIFO used to decouple the converter handshakes.
// Ports: clk, reset/clear (sync flush), datain/src_rdy_i/dst_rdy_o (write side),
//        dataout/src_rdy_o/dst_rdy_i (read side).
module fifo_short
  import fifo36_to_fifo19_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] datain,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [WIDTH-1:0] dataout,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i
);

  logic [WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_CW-1:0] count;
  logic               wr_en;
  logic               rd_en;

  assign dst_rdy_o = (count != FIFO_CW'(FIFO_DEPTH));
  assign src_rdy_o = (count != '0);
  assign wr_en     = src_rdy_i & dst_rdy_o;
  assign rd_en     = src_rdy_o & dst_rdy_i;
  assign dataout   = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + FIFO_CW'(1);
        2'b01:   count <= count - FIFO_CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= datain;
  end

endmodule

// File: rtl/fifo36_to_fifo19.sv
// fifo36_to_fifo19: splits each 36-bit packet line into one or two 19-bit lines.
// Ports: clk, reset, clear; f36_datain/f36_src_rdy_i/f36_dst_rdy_o (wide input),
//        f19_dataout/f19_src_rdy_o/f19_dst_rdy_i (narrow output), debug (status).
// LE=0 sends the upper 16 bits first, LE=1 the lower 16 bits first.
module fifo36_to_fifo19
  import fifo36_to_fifo19_pkg::*;
#(
  parameter bit LE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [F36_W-1:0]  f36_datain,
  input  logic              f36_src_rdy_i,
  output logic              f36_dst_rdy_o,
  output logic [F19_W-1:0]  f19_dataout,
  output logic              f19_src_rdy_o,
  input  logic              f19_dst_rdy_i,
  output logic [31:0]       debug
);

  logic [F36_W-1:0] f36_data_int;
  logic             f36_src_rdy_int;
  logic             f36_dst_rdy_int;
  logic [F19_W-1:0] f19_data_int;
  logic             f19_src_rdy_int;
  logic             f19_dst_rdy_int;

  f36_line_t         f36_line;
  f19_line_t         f19_line;
  logic [0:0]        phase;
  logic [0:0]        phase_nxt;
  logic              short_line;
  logic              xfer_out;
  logic [HALF_W-1:0] half_first;
  logic [HALF_W-1:0] half_second;

  fifo_short #(.WIDTH(F36_W)) head_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .datain    (f36_datain),
    .src_rdy_i (f36_src_rdy_i),
    .dst_rdy_o (f36_dst_rdy_o),
    .dataout   (f36_data_int),
    .src_rdy_o (f36_src_rdy_int),
    .dst_rdy_i (f36_dst_rdy_int)
  );

  fifo_short #(.WIDTH(F19_W)) tail_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .datain    (f19_data_int),
    .src_rdy_i (f19_src_rdy_int),
    .dst_rdy_o (f19_dst_rdy_int),
    .dataout   (f19_dataout),
    .src_rdy_o (f19_src_rdy_o),
    .dst_rdy_i (f19_dst_rdy_i)
  );

  assign f36_line     = f36_data_int;
  assign f19_data_int = f19_line;

  // Phase register
  always_ff @(posedge clk) begin
    if (reset || clear) phase <= PH0;
    else                phase <= phase_nxt;
  end

  // Half selection, flag mapping and handshake
  always_comb begin
    short_line      = f36_line.eof & ((f36_line.occ == OCC_1B) | (f36_line.occ == OCC_2B));
    half_first      = LE ? f36_line.data[15:0]  : f36_line.data[31:16];
    half_second     = LE ? f36_line.data[31:16] : f36_line.data[15:0];
    f19_src_rdy_int = f36_src_rdy_int;
    xfer_out        = f19_src_rdy_int & f19_dst_rdy_int;
    // A wide line is popped only once its final half has been written
    f36_dst_rdy_int = xfer_out & ((phase == PH1) | short_line);
    phase_nxt       = phase;
    f19_line        = '0;

    if (phase == PH0) begin
      f19_line.sof  = f36_line.sof;
      f19_line.eof  = short_line;
      f19_line.occ  = f36_line.eof & (f36_line.occ == OCC_1B);
      f19_line.data = half_first;
      if (xfer_out && !short_line) phase_nxt = PH1;
    end else begin
      f19_line.sof  = 1'b0;
      f19_line.eof  = f36_line.eof;
      f19_line.occ  = f36_line.eof & (f36_line.occ == OCC_3B);
      f19_line.data = half_second;
      if (xfer_out) phase_nxt = PH0;
    end
  end

  assign debug = {29'b0, f19_dst_rdy_int, f36_src_rdy_int, phase};

endmodule

// File: tb/tb_fifo36_to_fifo19.sv
// Self-checking bench for fifo36_to_fifo19: directed latency/occ/backpressure/clear
// cases plus randomized packets, checked against a byte-count reference model.
module tb_fifo36_to_fifo19;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [35:0] f36_datain;
  logic        f36_src_rdy_i;
  logic        f36_dst_rdy_o;
  logic [18:0] f19_dataout;
  logic        f19_src_rdy_o;
  logic        f19_dst_rdy_i;
  logic [31:0] debug;

  logic        f36_src_rdy_le;
  logic        f36_dst_rdy_le;
  logic [18:0] f19_data_le;
  logic        f19_src_rdy_le;
  logic [31:0] debug_le;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_out    = 0;
  bit          rand_dst = 1'b0;
  logic [18:0] exp_q [$];
  logic [18:0] mon_exp;

  always #5 clk = ~clk;

  fifo36_to_fifo19 #(.LE(1'b0)) dut (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .f36_datain    (f36_datain),
    .f36_src_rdy_i (f36_src_rdy_i),
    .f36_dst_rdy_o (f36_dst_rdy_o),
    .f19_dataout   (f19_dataout),
    .f19_src_rdy_o (f19_src_rdy_o),
    .f19_dst_rdy_i (f19_dst_rdy_i),
    .debug         (debug)
  );

  fifo36_to_fifo19 #(.LE(1'b1)) dut_le (
    .clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .f36_datain    (f36_datain),
    .f36_src_rdy_i (f36_src_rdy_le),
    .f36_dst_rdy_o (f36_dst_rdy_le),
    .f19_dataout   (f19_data_le),
    .f19_src_rdy_o (f19_src_rdy_le),
    .f19_dst_rdy_i (1'b1),
    .debug         (debug_le)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: count valid bytes on the wide line, hand two to each narrow line
  function automatic void model_push(input logic [35:0] w);
    int          nb;
    logic        eof;
    logic        sof;
    logic [15:0] first;
    logic [15:0] second;
    eof    = w[33];
    sof    = w[32];
    first  = w[31:16];
    second = w[15:0];
    nb     = 4;
    if (eof && w[35:34] != 2'd0) nb = int'(w[35:34]);
    if (nb <= 2) begin
      exp_q.push_back({(nb == 1), 1'b1, sof, first});
    end else begin
      exp_q.push_back({1'b0, 1'b0, sof, first});
      exp_q.push_back({(eof && nb == 3), eof, 1'b0, second});
    end
  endfunction

  // Scoreboard: compare every narrow transfer, record every wide acceptance
  always @(negedge clk) begin
    if (reset || clear) begin
      exp_q.delete();
    end else begin
      if (f19_src_rdy_o && f19_dst_rdy_i) begin
        n_out++;
        chk("f19_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("f19_line", 32'(f19_dataout), 32'(mon_exp));
        end
      end
      if (f36_src_rdy_i && f36_dst_rdy_o) model_push(f36_datain);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_dst) f19_dst_rdy_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    cyc();
    f36_src_rdy_i = 1'b0;
  endtask

  task automatic send_line(input logic [35:0] w, input int pct);
    bit done  = 1'b0;
    int guard = 0;
    while (!done && guard < 2000) begin
      cyc();
      f36_datain    = w;
      f36_src_rdy_i = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (f36_src_rdy_i && f36_dst_rdy_o) done = 1'b1;
      guard++;
    end
    chk("send_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      cyc();
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [35:0] bp [40];
    int          n0;
    int          acc;
    int          pkt_left;
    int          g;
    logic [35:0] w;

    reset          = 1'b1;
    clear          = 1'b0;
    f36_datain     = '0;
    f36_src_rdy_i  = 1'b0;
    f36_src_rdy_le = 1'b0;
    f19_dst_rdy_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_f36_dst_rdy", 32'(f36_dst_rdy_o), 32'd1);
    chk("rst_f19_src_rdy", 32'(f19_src_rdy_o), 32'd0);
    chk("rst_debug",       debug,               32'h4);
    chk("rst_le_dst_rdy",  32'(f36_dst_rdy_le), 32'd1);
    chk("rst_le_debug",    debug_le,            32'h4);

    // Latency and half order, both endiannesses
    cyc();
    f36_datain     = {2'd0, 1'b1, 1'b1, 32'hAABB_CCDD};
    f36_src_rdy_i  = 1'b1;
    f36_src_rdy_le = 1'b1;
    @(negedge clk);
    chk("lat_accept", 32'(f36_dst_rdy_o), 32'd1);
    cyc();
    f36_src_rdy_i  = 1'b0;
    f36_src_rdy_le = 1'b0;
    @(negedge clk);
    chk("lat_c1_valid", 32'(f19_src_rdy_o), 32'd0);
    chk("lat_c1_debug", debug, 32'h6);
    cyc();
    @(negedge clk);
    chk("lat_c2_valid", 32'(f19_src_rdy_o), 32'd1);
    chk("lat_c2_data",  32'(f19_dataout), 32'h1_AABB);
    chk("lat_c2_debug", debug, 32'h7);
    chk("le_c2_valid",  32'(f19_src_rdy_le), 32'd1);
    chk("le_c2_data",   32'(f19_data_le), 32'h1_CCDD);
    cyc();
    @(negedge clk);
    chk("lat_c3_data",  32'(f19_dataout), 32'h2_CCDD);
    chk("le_c3_data",   32'(f19_data_le), 32'h2_AABB);
    cyc();
    @(negedge clk);
    chk("lat_c4_valid", 32'(f19_src_rdy_o), 32'd0);

    // Partial last lines
    n0 = n_out;
    send_line({2'd1, 1'b1, 1'b1, 32'h1122_3344}, 100);
    send_line({2'd2, 1'b1, 1'b1, 32'h1122_3344}, 100);
    send_line({2'd3, 1'b1, 1'b1, 32'h1122_3344}, 100);
    idle();
    drain();
    chk("occ_beats", 32'(n_out - n0), 32'd4);

    // Randomized packets with ready toggling on both sides
    rand_dst = 1'b1;
    pkt_left = 0;
    for (int i = 0; i < 300; i++) begin
      w = '0;
      if (pkt_left == 0) begin
        pkt_left = int'($urandom_range(1, 6));
        w[32]    = 1'b1;
      end
      w[33]    = (pkt_left == 1);
      w[35:34] = 2'($urandom_range(0, 3));
      w[31:0]  = $urandom;
      send_line(w, 50);
      pkt_left--;
    end
    idle();
    drain();
    rand_dst      = 1'b0;
    f19_dst_rdy_i = 1'b1;

    // Backpressure: both FIFOs fill, then everything drains in order
    for (int i = 0; i < 40; i++) begin
      bp[i]         = {2'd0, 1'b0, 1'b0, $urandom};
      bp[i][32]     = (i == 0);
      bp[i][33]     = (i == 39);
    end
    f19_dst_rdy_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (acc < 40) begin
        f36_datain    = bp[acc];
        f36_src_rdy_i = 1'b1;
      end else begin
        f36_src_rdy_i = 1'b0;
      end
      @(negedge clk);
      if (f36_src_rdy_i && f36_dst_rdy_o) acc++;
    end
    chk("bp_accepted",   32'(acc), 32'd24);
    chk("bp_dst_rdy",    32'(f36_dst_rdy_o), 32'd0);
    chk("bp_tail_valid", 32'(f19_src_rdy_o), 32'd1);
    n0 = n_out;
    f19_dst_rdy_i = 1'b1;
    while (acc < 40) begin
      send_line(bp[acc], 100);
      acc++;
    end
    idle();
    drain();
    chk("bp_beats", 32'(n_out - n0), 32'd80);

    // Clear between the two halves of a line
    f19_dst_rdy_i = 1'b0;
    cyc();
    f36_datain    = {2'd0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    f36_src_rdy_i = 1'b1;
    @(negedge clk);
    cyc();
    f36_src_rdy_i = 1'b0;
    @(negedge clk);
    cyc();
    clear = 1'b1;
    @(negedge clk);
    chk("clr_mid_phase", 32'(debug[0]), 32'd1);
    cyc();
    clear = 1'b0;
    @(negedge clk);
    chk("clr_f19_valid", 32'(f19_src_rdy_o), 32'd0);
    chk("clr_debug",     debug, 32'h4);
    chk("clr_dst_rdy",   32'(f36_dst_rdy_o), 32'd1);
    f19_dst_rdy_i = 1'b1;
    send_line({2'd0, 1'b1, 1'b1, 32'h5566_7788}, 100);
    idle();
    g = 0;
    do begin
      cyc();
      @(negedge clk);
      g++;
    end while (!f19_src_rdy_o && g < 10);
    chk("post_clr_first", 32'(f19_dataout), 32'h1_5566);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
